datamemory_arbiter: RTL

//   Two-requester arbiter/sequencer for the single-port synchronous data memory (cs/we, 1-cycle registered read).

---
 rtl/datamemory_arbiter_if.sv | 45 ++++
 rtl/datamemory_arbiter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/datamemory_arbiter_if.sv
// Requester and memory bundles for the data-memory arbiter.
// Requester side holds req until gnt; memory side is single-port cs/we.
interface datamemory_arbiter_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 10
);
   logic                  req;
   logic                  we;
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] wdata;
   logic                  gnt;
   logic                  rvalid;
   logic [DATA_WIDTH-1:0] rdata;

   modport master (
      output req, we, addr, wdata,
      input  gnt, rvalid, rdata
   );

   modport slave (
      input  req, we, addr, wdata,
      output gnt, rvalid, rdata
   );
endinterface

interface datamemory_arbiter_mem_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 10
);
   logic                  cs;
   logic                  we;
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] din;
   logic [DATA_WIDTH-1:0] dout;

   modport master (
      output cs, we, addr, din,
      input  dout
   );

   modport slave (
      input  cs, we, addr, din,
      output dout
   );
endinterface

// File: rtl/datamemory_arbiter.sv
// Two-port arbiter/sequencer for a single-port sync data memory.
// DMEM_ARB_FIXED_PRIO_EN selects strict port-0 priority over round-robin.
module datamemory_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 10
) (
   input logic                       clk,
   input logic                       rst_n,
   datamemory_arbiter_if.slave       m0,
   datamemory_arbiter_if.slave       m1,
   datamemory_arbiter_mem_if.master  mem
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t                r_state;
   logic                  r_sel;
   logic                  r_we;
   logic                  r_gnt0;
   logic                  r_gnt1;
   logic                  r_rvalid0;
   logic                  r_rvalid1;
   logic [DATA_WIDTH-1:0] r_rdata0;
   logic [DATA_WIDTH-1:0] r_rdata1;
   logic                  r_cs;
   logic                  r_mem_we;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_din;
`ifndef DMEM_ARB_FIXED_PRIO_EN
   logic                  r_last;
   logic                  w_last_nxt;
`endif

   state_t                w_state_nxt;
   logic                  w_sel_nxt;
   logic                  w_we_nxt;
   logic                  w_gnt0_nxt;
   logic                  w_gnt1_nxt;
   logic                  w_rvalid0_nxt;
   logic                  w_rvalid1_nxt;
   logic [DATA_WIDTH-1:0] w_rdata0_nxt;
   logic [DATA_WIDTH-1:0] w_rdata1_nxt;
   logic                  w_cs_nxt;
   logic                  w_mem_we_nxt;
   logic [ADDR_WIDTH-1:0] w_addr_nxt;
   logic [DATA_WIDTH-1:0] w_din_nxt;
   logic                  w_any_req;
   logic                  w_win;

   assign w_any_req = m0.req | m1.req;

   // Winner: 0 = port 0, 1 = port 1; only meaningful when w_any_req.
`ifdef DMEM_ARB_FIXED_PRIO_EN
   assign w_win = ~m0.req;
`else
   assign w_win = (m0.req & m1.req) ? ~r_last : m1.req;
`endif

   always_comb begin
      w_state_nxt   = r_state;
      w_sel_nxt     = r_sel;
      w_we_nxt      = r_we;
      w_gnt0_nxt    = 1'b0;
      w_gnt1_nxt    = 1'b0;
      w_rvalid0_nxt = 1'b0;
      w_rvalid1_nxt = 1'b0;
      w_rdata0_nxt  = r_rdata0;
      w_rdata1_nxt  = r_rdata1;
      w_cs_nxt      = 1'b0;
      w_mem_we_nxt  = 1'b0;
      w_addr_nxt    = r_addr;
      w_din_nxt     = r_din;
`ifndef DMEM_ARB_FIXED_PRIO_EN
      w_last_nxt    = r_last;
`endif
      unique case (r_state)
         S_IDLE: begin
            if (w_any_req) begin
               w_state_nxt  = S_ISSUE;
               w_sel_nxt    = w_win;
               w_cs_nxt     = 1'b1;
`ifndef DMEM_ARB_FIXED_PRIO_EN
               w_last_nxt   = w_win;
`endif
               if (w_win) begin
                  w_we_nxt   = m1.we;
                  w_addr_nxt = m1.addr;
                  w_din_nxt  = m1.wdata;
                  w_gnt1_nxt = 1'b1;
               end else begin
                  w_we_nxt   = m0.we;
                  w_addr_nxt = m0.addr;
                  w_din_nxt  = m0.wdata;
                  w_gnt0_nxt = 1'b1;
               end
               w_mem_we_nxt = w_we_nxt;
            end
         end
         S_ISSUE: begin
            // Write commits at the end of ISSUE; no response phase.
            w_state_nxt = r_we ? S_IDLE : S_WAIT;
         end
         S_WAIT: begin
            w_state_nxt = S_RESP;
            if (r_sel) begin
               w_rdata1_nxt  = mem.dout;
               w_rvalid1_nxt = 1'b1;
            end else begin
               w_rdata0_nxt  = mem.dout;
               w_rvalid0_nxt = 1'b1;
            end
         end
         S_RESP: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_sel     <= 1'b0;
         r_we      <= 1'b0;
         r_gnt0    <= 1'b0;
         r_gnt1    <= 1'b0;
         r_rvalid0 <= 1'b0;
         r_rvalid1 <= 1'b0;
         r_rdata0  <= '0;
         r_rdata1  <= '0;
         r_cs      <= 1'b0;
         r_mem_we  <= 1'b0;
         r_addr    <= '0;
         r_din     <= '0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
         r_last    <= 1'b1;
`endif
      end else begin
         r_state   <= w_state_nxt;
         r_sel     <= w_sel_nxt;
         r_we      <= w_we_nxt;
         r_gnt0    <= w_gnt0_nxt;
         r_gnt1    <= w_gnt1_nxt;
         r_rvalid0 <= w_rvalid0_nxt;
         r_rvalid1 <= w_rvalid1_nxt;
         r_rdata0  <= w_rdata0_nxt;
         r_rdata1  <= w_rdata1_nxt;
         r_cs      <= w_cs_nxt;
         r_mem_we  <= w_mem_we_nxt;
         r_addr    <= w_addr_nxt;
         r_din     <= w_din_nxt;
`ifndef DMEM_ARB_FIXED_PRIO_EN
         r_last    <= w_last_nxt;
`endif
      end
   end

   assign m0.gnt    = r_gnt0;
   assign m0.rvalid = r_rvalid0;
   assign m0.rdata  = r_rdata0;
   assign m1.gnt    = r_gnt1;
   assign m1.rvalid = r_rvalid1;
   assign m1.rdata  = r_rdata1;
   assign mem.cs    = r_cs;
   assign mem.we    = r_mem_we;
   assign mem.addr  = r_addr;
   assign mem.din   = r_din;

endmodule
